multi_channel_pulser: RTL and testbench

Parametrised successor to the single-pulser. It takes CH asynchronous push-button inputs and, per channel, applies a synchroniser, a debounce filter and an edge-mode select. It emits one-cycle pulses, with optional hold-to-auto-repeat. It sits between the board button pins and the FSM/control logic that consumes press events.

---
 rtl/multi_channel_pulser.sv | 168 ++++++++++++++++
 tb/tb_multi_channel_pulser.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_pulser.sv
// multi_channel_pulser
// Turns CH raw push-button pins into clean press events. Each channel is
// handled independently: synchroniser chain, debounce filter, edge-mode
// select and an optional hold-to-auto-repeat state machine.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   btn_i        raw asynchronous button levels, bit n = channel n
//   level_o      debounced level per channel
//   pulse_o      registered one-cycle event pulse per channel
//   any_pulse_o  OR of pulse_o
module multi_channel_pulser #(
  parameter int CH            = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int DB_CYCLES     = 4,
  parameter int EDGE_MODE     = 0,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_DELAY  = 16,
  parameter int REPEAT_PERIOD = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] btn_i,
  output logic [CH-1:0] level_o,
  output logic [CH-1:0] pulse_o,
  output logic          any_pulse_o
);

  // Counter widths; a limit of 1 still needs a 1-bit counter.
  localparam int DB_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RP_W   = (RP_MAX > 1) ? $clog2(RP_MAX) : 1;

  localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DB_CYCLES - 1);
  localparam logic [RP_W-1:0] DELAY_LAST  = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] PERIOD_LAST = RP_W'(REPEAT_PERIOD - 1);

  // Level that counts as "pressed": low only in falling-edge mode.
  localparam logic ACTIVE = (EDGE_MODE == 1) ? 1'b0 : 1'b1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  genvar gi;

  if (CH < 1 || SYNC_STAGES < 1 || DB_CYCLES < 1 || EDGE_MODE < 0 || EDGE_MODE > 2 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_error
    $error("multi_channel_pulser: illegal parameter value");
  end

  // Synchroniser: one CH-wide register per stage.
  logic [CH-1:0] sync_reg [SYNC_STAGES];

  for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    if (gi == 0) begin : g_first
      always_ff @(posedge clk) begin
        if (rst) sync_reg[gi] <= '0;
        else     sync_reg[gi] <= btn_i;
      end
    end else begin : g_next
      always_ff @(posedge clk) begin
        if (rst) sync_reg[gi] <= '0;
        else     sync_reg[gi] <= sync_reg[gi-1];
      end
    end
  end

  for (gi = 0; gi < CH; gi++) begin : g_ch
    logic            s;
    logic [DB_W-1:0] db_cnt_reg;
    logic            level_reg;
    logic            change;
    logic            edge_evt;
    logic            enter_active;
    logic            leave_active;
    logic [1:0]      state_reg, state_next;
    logic [RP_W-1:0] rp_cnt_reg, rp_cnt_next;
    logic            rep_evt;
    logic            pulse_reg;

    assign s = sync_reg[SYNC_STAGES-1][gi];

    // Accept s only after it has differed from the level for DB_CYCLES
    // consecutive cycles; any return to the level restarts the count.
    assign change = (s != level_reg) && (db_cnt_reg == DB_LAST);

    always_ff @(posedge clk) begin
      if (rst) begin
        db_cnt_reg <= '0;
        level_reg  <= 1'b0;
      end else if (s == level_reg) begin
        db_cnt_reg <= '0;
      end else if (change) begin
        level_reg  <= s;
        db_cnt_reg <= '0;
      end else begin
        db_cnt_reg <= db_cnt_reg + DB_W'(1);
      end
    end

    // s is the new level whenever change is high.
    assign enter_active = change && (s == ACTIVE);
    assign leave_active = change && (s != ACTIVE);
    assign edge_evt     = (EDGE_MODE == 2) ? change : enter_active;

    // Auto-repeat. A release has priority over a repeat scheduled for the
    // same edge, so the repeat is dropped rather than fired late.
    always_comb begin
      state_next  = state_reg;
      rp_cnt_next = rp_cnt_reg;
      rep_evt     = 1'b0;
      if (REPEAT_EN == 0) begin
        state_next  = ST_IDLE;
        rp_cnt_next = '0;
      end else if (leave_active) begin
        state_next  = ST_IDLE;
        rp_cnt_next = '0;
      end else if (enter_active) begin
        state_next  = ST_DELAY;
        rp_cnt_next = '0;
      end else begin
        case (state_reg)
          ST_DELAY: begin
            if (rp_cnt_reg == DELAY_LAST) begin
              rep_evt     = 1'b1;
              rp_cnt_next = '0;
              state_next  = ST_REPEAT;
            end else begin
              rp_cnt_next = rp_cnt_reg + RP_W'(1);
            end
          end
          ST_REPEAT: begin
            if (rp_cnt_reg == PERIOD_LAST) begin
              rep_evt     = 1'b1;
              rp_cnt_next = '0;
            end else begin
              rp_cnt_next = rp_cnt_reg + RP_W'(1);
            end
          end
          default: begin
            state_next  = ST_IDLE;
            rp_cnt_next = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_reg  <= ST_IDLE;
        rp_cnt_reg <= '0;
        pulse_reg  <= 1'b0;
      end else begin
        state_reg  <= state_next;
        rp_cnt_reg <= rp_cnt_next;
        pulse_reg  <= edge_evt | rep_evt;
      end
    end

    assign level_o[gi] = level_reg;
    assign pulse_o[gi] = pulse_reg;
  end

  assign any_pulse_o = |pulse_o;

endmodule

// File: tb/tb_multi_channel_pulser.sv
// Testbench for multi_channel_pulser. Three instances share clk/rst:
//   dut_a  default parameters (rising edge, no repeat)
//   dut_b  EDGE_MODE = 2
//   dut_c  REPEAT_EN = 1, REPEAT_DELAY = 16, REPEAT_PERIOD = 4
// Stimulus pushes the expected (cycle, pulse vector) of every pulse into a
// per-instance queue; a negedge monitor pops and compares whenever an
// instance drives a pulse. Leftover expectations are reported at the end.
module tb_multi_channel_pulser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_a = '0, btn_b = '0, btn_c = '0;
  logic [3:0] level_a, level_b, level_c;
  logic [3:0] pulse_a, pulse_b, pulse_c;
  logic       any_a, any_b, any_c;

  int cyc      = 0;
  int n_checks = 0;
  int n_pass   = 0;
  bit done     = 1'b0;

  typedef struct {
    int         cyc;
    logic [3:0] vec;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  multi_channel_pulser dut_a (
    .clk(clk), .rst(rst), .btn_i(btn_a),
    .level_o(level_a), .pulse_o(pulse_a), .any_pulse_o(any_a)
  );

  multi_channel_pulser #(.EDGE_MODE(2)) dut_b (
    .clk(clk), .rst(rst), .btn_i(btn_b),
    .level_o(level_b), .pulse_o(pulse_b), .any_pulse_o(any_b)
  );

  multi_channel_pulser #(.REPEAT_EN(1), .REPEAT_DELAY(16), .REPEAT_PERIOD(4)) dut_c (
    .clk(clk), .rst(rst), .btn_i(btn_c),
    .level_o(level_c), .pulse_o(pulse_c), .any_pulse_o(any_c)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges so far; read at negedges only.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic push_exp(input int id, input int c, input logic [3:0] v);
    exp_t e;
    e.cyc = c;
    e.vec = v;
    case (id)
      0:       qa.push_back(e);
      1:       qb.push_back(e);
      default: qc.push_back(e);
    endcase
  endtask

  task automatic check_out(input int id, input logic [3:0] p, input logic a);
    exp_t e;
    bit   have;
    have = 1'b0;
    if (p != 4'b0 || a) begin
      chk($sformatf("any_pulse dut%0d", id), {31'b0, a}, {31'b0, |p});
      if (p != 4'b0) begin
        case (id)
          0:       if (qa.size() > 0) begin e = qa.pop_front(); have = 1'b1; end
          1:       if (qb.size() > 0) begin e = qb.pop_front(); have = 1'b1; end
          default: if (qc.size() > 0) begin e = qc.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
          chk($sformatf("unexpected pulse dut%0d", id), {28'b0, p}, 32'b0);
        end else begin
          $display("pulse dut%0d cycle %0d vec %b (expected cycle %0d vec %b)",
                   id, cyc, p, e.cyc, e.vec);
          chk($sformatf("pulse cycle dut%0d", id), cyc, e.cyc);
          chk($sformatf("pulse vec dut%0d", id), {28'b0, p}, {28'b0, e.vec});
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!done) begin
      check_out(0, pulse_a, any_a);
      check_out(1, pulse_b, any_b);
      check_out(2, pulse_c, any_c);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int c;
    int t;

    // Reset state
    rst = 1'b1;
    step(3);
    chk("reset level_a", {28'b0, level_a}, 32'b0);
    chk("reset pulse_a", {28'b0, pulse_a}, 32'b0);
    chk("reset level_c", {28'b0, level_c}, 32'b0);
    chk("reset any_b",   {31'b0, any_b},   32'b0);
    rst = 1'b0;
    step(5);

    // 1: single press on ch0, latency 6 edges, held with no further pulses
    c = cyc;
    btn_a = 4'b0001;
    push_exp(0, c + 6, 4'b0001);
    step(5);
    chk("t1 level before latency", {28'b0, level_a}, 32'b0);
    step(1);
    chk("t1 level at latency", {28'b0, level_a}, 32'h1);
    step(24);
    btn_a = 4'b0000;
    step(10);
    chk("t1 level after release", {28'b0, level_a}, 32'b0);

    // 2: bounce on ch1 (2-cycle glitches), then held high
    for (int k = 0; k < 6; k++) begin
      btn_a[1] = (k % 2 == 0);
      step(2);
    end
    chk("t2 level during bounce", {28'b0, level_a}, 32'b0);
    btn_a[1] = 1'b1;
    push_exp(0, cyc + 6, 4'b0010);
    step(10);
    btn_a = 4'b0000;
    step(10);

    // 5: channels 0 and 3 together
    c = cyc;
    btn_a = 4'b1001;
    push_exp(0, c + 6, 4'b1001);
    step(10);
    btn_a = 4'b0000;
    step(10);

    // 3: both-edge mode, ch2 pressed for 10 cycles
    c = cyc;
    btn_b = 4'b0100;
    push_exp(1, c + 6, 4'b0100);
    step(10);
    btn_b = 4'b0000;
    push_exp(1, c + 16, 4'b0100);
    step(12);
    chk("t3 level after release", {28'b0, level_b}, 32'b0);

    // 4: auto-repeat, release level change lands on a scheduled repeat
    c = cyc;
    t = c + 6;
    btn_c = 4'b0001;
    push_exp(2, t, 4'b0001);
    for (int k = 0; k < 6; k++) push_exp(2, t + 16 + 4 * k, 4'b0001);
    step(40);
    btn_c = 4'b0000;
    step(15);
    chk("t4 level after release", {28'b0, level_c}, 32'b0);

    // 6: reset while in REPEAT with button held, then fresh schedule
    c = cyc;
    t = c + 6;
    btn_c = 4'b0001;
    push_exp(2, t, 4'b0001);
    push_exp(2, t + 16, 4'b0001);
    push_exp(2, t + 20, 4'b0001);
    step(28);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("t6 reset level_c", {28'b0, level_c}, 32'b0);
    chk("t6 reset pulse_c", {28'b0, pulse_c}, 32'b0);
    chk("t6 reset any_c",   {31'b0, any_c},   32'b0);
    t = cyc + 6;
    push_exp(2, t, 4'b0001);
    push_exp(2, t + 16, 4'b0001);
    push_exp(2, t + 20, 4'b0001);
    push_exp(2, t + 24, 4'b0001);
    step(27);
    btn_c = 4'b0000;
    step(15);
    chk("t6 level after release", {28'b0, level_c}, 32'b0);

    done = 1'b1;
    foreach (qa[i]) chk($sformatf("missing pulse dut0 cycle %0d", qa[i].cyc), 32'b0, {28'b0, qa[i].vec});
    foreach (qb[i]) chk($sformatf("missing pulse dut1 cycle %0d", qb[i].cyc), 32'b0, {28'b0, qb[i].vec});
    foreach (qc[i]) chk($sformatf("missing pulse dut2 cycle %0d", qc[i].cyc), 32'b0, {28'b0, qc[i].vec});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
